mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//  Bus initiator for the 16x8 data RAM port (mem_read/mem_write/addr/wdata/rdata).
//  Runs block copy or block fill jobs without the core: reads src, writes dst.
//  Sits beside the ControlUnit; a mux (outside this block) hands it the RAM port while busy=1.
// PARAMETERS
//  ADDR_W  8  address width driven on addr; RAM decodes addr[3:0]
//  DATA_W  8  data width of wdata/rdata/fill_value
//  LEN_W   5  job length width; legal len 0..16, larger values saturate to 16
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       job request, sampled in IDLE only
//  mode        in   1       0=copy, 1=fill
//  src_addr    in   ADDR_W  copy source base (ignored in fill)
//  dst_addr    in   ADDR_W  destination base
//  len         in   LEN_W   byte count
//  fill_value  in   DATA_W  fill byte
//  abort       in   1       synchronous cancel
//  busy        out  1       job in progress (state != IDLE && state != DONE)
//  done        out  1       one-cycle completion pulse
//  mem_read    out  1       RAM read strobe
//  mem_write   out  1       RAM write strobe
//  addr        out  ADDR_W  RAM address
//  wdata       out  DATA_W  RAM write data
//  rdata       in   DATA_W  RAM read data, combinational from addr/mem_read
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, DONE. Strobes/addr/wdata decoded from registers only (Moore).
//  - Reset (async): state=IDLE; busy=done=mem_read=mem_write=0; addr=wdata=0; counters/buffer=0.
//  - IDLE: start=1 & abort=0 latches src,dst,mode,fill_value,len(sat 16) at the edge.
//    len=0 -> DONE; mode=copy -> READ; mode=fill -> WRITE. start in any other state ignored.
//  - READ: mem_read=1, addr=src_ptr; rdata captured into buffer at the end of the cycle; -> WRITE.
//  - WRITE: mem_write=1, addr=dst_ptr, wdata=buffer (copy) or fill_value (fill);
//    at edge: dst_ptr+1, src_ptr+1 (copy), remaining-1; remaining==1 -> DONE,
//    else -> READ (copy) / WRITE (fill).
//  - DONE: done=1 for exactly one cycle, busy=0, no strobes; -> IDLE.
//  - Throughput: copy 2 cycles/byte, fill 1 cycle/byte. Start sampled at edge 0:
//    copy N -> done high in cycle 2N+1; fill N -> cycle N+1; len=0 -> cycle 1.
//  - Pointers are ADDR_W-bit, wrap modulo 2^ADDR_W (0xFF+1=0x00); RAM aliasing is not this block's concern.
//  - Overlapping src/dst: strictly ascending byte order, no hazard handling.
//  - abort=1 in READ/WRITE: -> IDLE next edge, no done pulse, strobes drop that edge;
//    a write already in the abort cycle still commits. abort wins over start in IDLE.
//  - mem_read and mem_write never both 1; both 0 in IDLE/DONE.
//  - Async reset mid-job: strobes drop immediately, job lost, no done.
// CONFIGURATION
//  MEM_COPY_CHECKSUM_EN defined: extra output checksum[DATA_W-1:0] = XOR of all bytes written
//    in the current job; cleared on job accept, updated on each WRITE edge, held after DONE
//    until the next accept, reset to 0. Undefined: port and logic absent.
// TESTING
//  - Reset: rst_n=0 mid-copy -> mem_read=mem_write=busy=done=0 without a clock edge.
//  - Copy: RAM[0..3]=11,22,33,44; start copy src=0 dst=8 len=4 -> RAM[8..11]=11,22,33,44,
//    done in cycle 9, strobes alternate R,W.
//  - Fill: dst=0x0E len=4 fill=0xA5 -> writes to addr 0E,0F,10,11 on consecutive cycles; done in cycle 5.
//  - len=0 and len=20: len=0 -> no strobes, done in cycle 1; len=20 -> exactly 16 writes.
//  - Abort after 2nd write of len=8 copy -> exactly 2 bytes written, no done, busy=0 next cycle;
//    start while busy ignored.
//  - MEM_COPY_CHECKSUM_EN: fill 3 bytes of 0x0F -> checksum=0x0F; copy 11,22 -> checksum=0x33.

Source files
------------

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//   Bus initiator for the 16x8 data RAM port. Runs block copy (read src,
//   write dst) or block fill (write fill_value to dst) jobs without the core.
//   An external mux hands this block the RAM port while busy=1.
//
//   Optional feature: define MEM_COPY_CHECKSUM_EN to add a `checksum` output
//   holding the XOR of every byte written in the current job.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       job request, sampled only in IDLE
//   mode        0 = copy, 1 = fill
//   src_addr    copy source base (ignored for fill)
//   dst_addr    destination base
//   len         byte count; values above 16 saturate to 16
//   fill_value  fill byte
//   abort       synchronous cancel of a running job
//   busy        job in progress (READ or WRITE)
//   done        one-cycle completion pulse
//   mem_read    RAM read strobe
//   mem_write   RAM write strobe
//   addr        RAM address
//   wdata       RAM write data
//   rdata       RAM read data (combinational from addr/mem_read)
//   checksum    (MEM_COPY_CHECKSUM_EN only) XOR of bytes written this job
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(32'd16);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(32'd1);
    localparam logic [LEN_W-1:0]  LEN_ZERO = LEN_W'(32'd0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(32'd1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   src_ptr_r;
    logic [ADDR_W-1:0]   dst_ptr_r;
    logic [LEN_W-1:0]    rem_r;
    logic                mode_r;
    logic [DATA_W-1:0]   fill_r;
    logic [DATA_W-1:0]   buf_r;
    logic [LEN_W-1:0]    len_sat_s;
    logic                accept_s;
    logic [DATA_W-1:0]   wdata_s;

    // Saturate the requested length to the RAM depth
    always_comb begin
        if (len > MAX_LEN) begin
            len_sat_s = MAX_LEN;
        end else begin
            len_sat_s = len;
        end
    end

    // abort takes priority over start when both arrive in IDLE
    assign accept_s = (state_r == ST_IDLE) && start && !abort;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (len_sat_s == LEN_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else if (mode) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (rem_r == LEN_ONE) begin
                    state_nxt_s = ST_DONE;
                end else if (mode_r) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job registers: latch on accept, advance pointers on every write edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr_r <= '0;
            dst_ptr_r <= '0;
            rem_r     <= '0;
            mode_r    <= 1'b0;
            fill_r    <= '0;
            buf_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        src_ptr_r <= src_addr;
                        dst_ptr_r <= dst_addr;
                        rem_r     <= len_sat_s;
                        mode_r    <= mode;
                        fill_r    <= fill_value;
                    end
                end
                ST_READ: begin
                    buf_r <= rdata;
                end
                ST_WRITE: begin
                    // Pointers wrap naturally at 2^ADDR_W
                    dst_ptr_r <= dst_ptr_r + PTR_ONE;
                    rem_r     <= rem_r - LEN_ONE;
                    if (!mode_r) begin
                        src_ptr_r <= src_ptr_r + PTR_ONE;
                    end
                end
                default: begin
                    buf_r <= buf_r;
                end
            endcase
        end
    end

    // Moore output decode: every output depends on registers only, so an
    // asynchronous reset drops the strobes immediately
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata_s   = '0;
        case (state_r)
            ST_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                addr     = src_ptr_r;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                addr      = dst_ptr_r;
                if (mode_r) begin
                    wdata_s = fill_r;
                end else begin
                    wdata_s = buf_r;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign wdata = wdata_s;

`ifdef MEM_COPY_CHECKSUM_EN
    function automatic logic [DATA_W-1:0] xor_accum(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] data);
        return acc ^ data;
    endfunction

    // Checksum: cleared on accept, folded on each write edge, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept_s) begin
            checksum <= '0;
        end else if (state_r == ST_WRITE) begin
            checksum <= xor_accum(checksum, wdata_s);
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [4:0] len;
    logic [7:0] fill_value;
    logic       abort;
    logic       busy;
    logic       done;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .wdata(wdata), .rdata(rdata)
`ifdef MEM_COPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 16x8, decodes addr[3:0]
    logic [7:0] ram [16];
    logic       ram_init_req;

    function automatic logic [7:0] init_val(input int i);
        if (i < 4) return 8'(17 * (i + 1));
        else       return 8'(8'hF0 ^ 8'(i));
    endfunction

    always @(posedge clk) begin
        if (ram_init_req) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
        end else if (mem_write) begin
            ram[addr[3:0]] <= wdata;
        end
    end

    assign rdata = mem_read ? ram[addr[3:0]] : 8'h00;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic       mode;
        logic [7:0] src;
        logic [7:0] dst;
        logic [4:0] len;
        logic [7:0] fill;
        int         exp_cycle;
        int         exp_writes;
        logic [7:0] exp_chk;
    } job_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_wr = 0;
    int         n_rd = 0;
    int         n_done = 0;
    logic       cur_copy = 1'b0;
    logic       have_prev = 1'b0;
    logic       prev_w = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle scoreboard, called #1 after each rising edge
    task automatic monitor();
        wr_t        e;
        logic [7:0] ra;
        if (busy) check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
        if (mem_write) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                check("extra_write", 32'd1, 32'd0);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 32'(addr), 32'(e.a));
                check("wr_data", 32'(wdata), 32'(e.d));
            end
        end
        if (mem_read) begin
            n_rd++;
            if (rd_q.size() == 0) begin
                check("extra_read", 32'd1, 32'd0);
            end else begin
                ra = rd_q.pop_front();
                check("rd_addr", 32'(addr), 32'(ra));
            end
        end
        if (cur_copy && busy) begin
            if (have_prev) check("alternate", 32'(mem_write), 32'(!prev_w));
            have_prev = 1'b1;
            prev_w    = mem_write;
        end else begin
            have_prev = 1'b0;
        end
        if (done) n_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic init_ram();
        ram_init_req = 1'b1;
        @(posedge clk);
        #1;
        ram_init_req = 1'b0;
    endtask

    task automatic push_expect(input job_t j, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            wr_q.push_back({8'(int'(j.dst) + k),
                            j.mode ? j.fill : init_val((int'(j.src) + k) & 15)});
            if (!j.mode) rd_q.push_back(8'(int'(j.src) + k));
        end
    endtask

    task automatic drive_start(input job_t j);
        mode       = j.mode;
        src_addr   = j.src;
        dst_addr   = j.dst;
        len        = j.len;
        fill_value = j.fill;
        start      = 1'b1;
    endtask

    task automatic run_job(input job_t j, input int idx);
        int eff;
        int cyc;
        int wr0;
        int rd0;
        init_ram();
        eff = (j.len > 5'd16) ? 16 : int'(j.len);
        push_expect(j, eff);
        cur_copy = !j.mode;
        wr0 = n_wr;
        rd0 = n_rd;
        drive_start(j);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        monitor();
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check($sformatf("job%0d_done_cycle", idx), 32'(cyc), 32'(j.exp_cycle));
        check($sformatf("job%0d_idle_at_done", idx), {29'd0, busy, mem_read, mem_write}, 32'd0);
        check($sformatf("job%0d_writes", idx), 32'(n_wr - wr0), 32'(j.exp_writes));
        check($sformatf("job%0d_reads", idx), 32'(n_rd - rd0), j.mode ? 32'd0 : 32'(j.exp_writes));
        check($sformatf("job%0d_queue_left", idx), 32'(wr_q.size() + rd_q.size()), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check($sformatf("job%0d_checksum", idx), 32'(checksum), 32'(j.exp_chk));
`endif
        tick();
        check($sformatf("job%0d_done_pulse", idx), 32'(done), 32'd0);
        wr_q.delete();
        rd_q.delete();
    endtask

    job_t jobs[8];
    job_t jab;
    int   dn0;
    int   wr0;

    initial begin
        // mode, src, dst, len, fill, done cycle, writes, checksum
        jobs[0] = '{1'b0, 8'h00, 8'h08, 5'd4,  8'h00, 9,  4,  8'h44};
        jobs[1] = '{1'b1, 8'h00, 8'h0E, 5'd4,  8'hA5, 5,  4,  8'h00};
        jobs[2] = '{1'b0, 8'h00, 8'h08, 5'd0,  8'h00, 1,  0,  8'h00};
        jobs[3] = '{1'b1, 8'h00, 8'h20, 5'd20, 8'h3C, 17, 16, 8'h00};
        jobs[4] = '{1'b0, 8'hFE, 8'h45, 5'd3,  8'h00, 7,  3,  8'h10};
        jobs[5] = '{1'b1, 8'h00, 8'hFF, 5'd1,  8'h5A, 2,  1,  8'h5A};
        jobs[6] = '{1'b1, 8'h00, 8'h30, 5'd3,  8'h0F, 4,  3,  8'h0F};
        jobs[7] = '{1'b0, 8'h00, 8'h28, 5'd2,  8'h00, 5,  2,  8'h33};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = 8'h00; dst_addr = 8'h00;
        len = 5'd0; fill_value = 8'h00; abort = 1'b0; ram_init_req = 1'b0;
        #3;
        check("rst_ctrl", {28'd0, busy, done, mem_read, mem_write}, 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        #9;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_job(jobs[i], i);

        // abort together with start in IDLE: nothing happens
        drive_start(jobs[0]);
        abort = 1'b1;
        dn0 = n_done;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        tick();
        check("abort_start_nodone", 32'(n_done - dn0), 32'd0);

        // abort during the 2nd write of an 8-byte copy; start while busy ignored
        init_ram();
        jab = '{1'b0, 8'h00, 8'h08, 5'd8, 8'h00, 0, 2, 8'h00};
        push_expect(jab, 2);
        cur_copy = 1'b1;
        wr0 = n_wr;
        dn0 = n_done;
        drive_start(jab);
        tick();                                    // cycle 1: READ
        start = 1'b0;
        tick();                                    // cycle 2: WRITE
        jab.mode = 1'b1; jab.fill = 8'hEE; jab.dst = 8'h00;
        drive_start(jab);                          // must be ignored
        tick();                                    // cycle 3: READ
        start = 1'b0;
        tick();                                    // cycle 4: WRITE #2
        abort = 1'b1;
        tick();                                    // cycle 5
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 20; c++) tick();
        check("abort_writes", 32'(n_wr - wr0), 32'd2);
        check("abort_nodone", 32'(n_done - dn0), 32'd0);
        check("abort_queue", 32'(wr_q.size() + rd_q.size()), 32'd0);

        // asynchronous reset mid-copy drops strobes without a clock edge
        init_ram();
        push_expect(jobs[0], 4);
        cur_copy = 1'b1;
        drive_start(jobs[0]);
        tick();
        start = 1'b0;
        tick();
        tick();                                    // cycle 3: READ
        check("pre_reset_read", 32'(mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_strobes", {28'd0, busy, done, mem_read, mem_write}, 32'd0);
        wr_q.delete();
        rd_q.delete();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {28'd0, busy, done, mem_read, mem_write}, 32'd0);
        run_job(jobs[7], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
